// File: rtl/radix_booth_mult.sv
// Sequential signed WIDTH x WIDTH radix-4 Booth multiplier with one shared adder. Result appears after 1 capture + WIDTH/2 enabled edges.
// en low freezes all state; a new product needs a reset pulse. Optional done port under RADIX_BOOTH_DONE_EN.
module radix_booth_mult #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
`ifdef RADIX_BOOTH_DONE_EN
   output logic               done,
`endif
   output logic [2*WIDTH-1:0] OUT
);

   // High half carries one guard bit beyond what the partial-sum bound needs.
   localparam int HW = WIDTH + 3;
   localparam int CW = $clog2(WIDTH/2 + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH/2 - 1);

   typedef enum logic [1:0] {LOAD, BUSY, DONE} state_t;

   state_t                    state;
   logic signed [WIDTH+1:0]   mcand;
   logic [WIDTH:0]            mplier;
   logic signed [HW-1:0]      hi;
   logic [WIDTH-1:0]          lo;
   logic [CW-1:0]             cnt;

   logic signed [HW-1:0]       m_ext;
   logic signed [HW-1:0]       pp;
   logic signed [HW-1:0]       sum;
   logic signed [HW+WIDTH-1:0] nxt;

   // Booth digit from the low triplet; the accumulator shifts right two bits per digit.
   always_comb begin
      m_ext = {{(HW-WIDTH-2){mcand[WIDTH+1]}}, mcand};
      pp    = '0;
      case (mplier[2:0])
         3'b001, 3'b010: pp = m_ext;
         3'b011:         pp = m_ext <<< 1;
         3'b100:         pp = -(m_ext <<< 1);
         3'b101, 3'b110: pp = -m_ext;
         default:        pp = '0;
      endcase
      sum = hi + pp;
      nxt = $signed({sum, lo}) >>> 2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= LOAD;
         OUT    <= '0;
         mcand  <= '0;
         mplier <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
`ifdef RADIX_BOOTH_DONE_EN
         done   <= 1'b0;
`endif
      end else if (en) begin
         case (state)
            LOAD: begin
               mcand  <= {{2{A[WIDTH-1]}}, A};
               mplier <= {B, 1'b0};
               hi     <= '0;
               lo     <= '0;
               cnt    <= '0;
               state  <= BUSY;
            end
            BUSY: begin
               hi     <= nxt[HW+WIDTH-1:WIDTH];
               lo     <= nxt[WIDTH-1:0];
               mplier <= mplier >> 2;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  OUT   <= nxt[2*WIDTH-1:0];
                  state <= DONE;
`ifdef RADIX_BOOTH_DONE_EN
                  done  <= 1'b1;
`endif
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_radix_booth_mult.sv
// Directed scoreboard bench for radix_booth_mult: signs, identities, Booth extremes, en stalls, abort and operand changes.
module tb_radix_booth_mult;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] A;
   logic [31:0] B;
   logic [63:0] OUT;
`ifdef RADIX_BOOTH_DONE_EN
   logic        done;
`endif

   int total = 0;
   int bad   = 0;
   longint exp_q[$];

   radix_booth_mult #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .A   (A),
      .B   (B),
`ifdef RADIX_BOOTH_DONE_EN
      .done(done),
`endif
      .OUT (OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reset, capture, run 16 BUSY edges (optionally stalling / changing operands), check product.
   task automatic run_case(input logic signed [31:0] a, input logic signed [31:0] b,
                           input bit stall, input bit chg);
      int     edges;
      int     guard;
      bit     seen8;
      bit     seen16;
      longint e;
      @(negedge clk);
      rst = 1'b0; en = 1'b0; A = a; B = b;
      #1;
      chk("reset_out", OUT, 64'd0);
`ifdef RADIX_BOOTH_DONE_EN
      chk("reset_done", {63'd0, done}, 64'd0);
`endif
      @(negedge clk);
      rst = 1'b1;
      exp_q.push_back(longint'(a) * longint'(b));
      edges = 0; guard = 0; seen8 = 0; seen16 = 0;
      while (edges < 17 && guard < 400) begin
         en = (stall && edges > 0 && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         if (chg && edges > 0) begin
            A = $urandom;
            B = $urandom;
         end
         @(posedge clk);
         if (en) edges++;
         guard++;
         @(negedge clk);
         if (edges == 8 && !seen8) begin
            seen8 = 1;
            chk("busy_out_mid", OUT, 64'd0);
         end
         if (edges == 16 && !seen16) begin
            seen16 = 1;
            chk("busy_out_last", OUT, 64'd0);
`ifdef RADIX_BOOTH_DONE_EN
            chk("busy_done", {63'd0, done}, 64'd0);
`endif
         end
      end
      chk("edge_budget", 64'(edges), 64'd17);
      e = exp_q.pop_front();
      chk("product", OUT, e);
`ifdef RADIX_BOOTH_DONE_EN
      chk("done_high", {63'd0, done}, 64'd1);
`endif
      A = ~A; B = $urandom; en = 1'b1;
      repeat (3) @(negedge clk);
      chk("done_hold", OUT, e);
   endtask

   initial begin
      int edges;
      rst = 1'b0; en = 1'b0; A = '0; B = '0;
      #12;

      run_case(12, -32, 0, 0);
      chk("const_12x-32", OUT, 64'hFFFF_FFFF_FFFF_FE80);
      run_case(5, 15, 0, 0);
      run_case(-51, -4, 0, 0);
      run_case(-25, -60, 0, 0);
      run_case(0, 1234, 0, 0);
      run_case(1, 12, 0, 0);
      run_case(-12, 72, 0, 0);
      run_case(13, 20, 0, 0);
      run_case(32'sh8000_0000, 32'sh8000_0000, 0, 0);
      chk("const_min_sq", OUT, 64'h4000_0000_0000_0000);
      run_case(32'sh8000_0000, 32'sh7FFF_FFFF, 0, 0);
      chk("const_min_x_max", OUT, 64'hC000_0000_8000_0000);
      run_case(-1, 32'sh5555_5555, 0, 0);
      run_case(-1, 32'shAAAA_AAAA, 0, 0);
      run_case(32'sh1234_5678, -32'sd987654321, 1, 0);
      run_case(-32'sd7777777, 32'sh7FFF_0001, 1, 0);
      run_case(32'sh7654_3210, 32'sh8765_4321, 0, 1);

      // Abort mid-operation: capture plus 8 BUSY edges, then reset.
      @(negedge clk);
      rst = 1'b0; en = 1'b0; A = 32'd99999; B = 32'd77777;
      @(negedge clk);
      rst = 1'b1; en = 1'b1;
      exp_q.push_back(longint'(32'sd99999) * longint'(32'sd77777));
      edges = 0;
      repeat (9) begin
         @(posedge clk);
         edges++;
      end
      @(negedge clk);
      chk("abort_edges", 64'(edges), 64'd9);
      rst = 1'b0;
      #1;
      chk("abort_out", OUT, 64'd0);
`ifdef RADIX_BOOTH_DONE_EN
      chk("abort_done", {63'd0, done}, 64'd0);
`endif
      void'(exp_q.pop_front());
      run_case(7, -3, 0, 0);
      chk("const_7x-3", OUT, 64'hFFFF_FFFF_FFFF_FFEB);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/radix_booth_mult.md
# radix_booth_mult

Sequential signed 32×32 multiplier using radix-4 (modified) Booth recoding; it produces a 64-bit two's-complement product after a fixed number of clock cycles. It serves as the low-area multiplier option in the arithmetic block set, trading latency for a single shared adder. Its port set matches the other sequential multipliers so they can be swapped at the instantiation site.

## Interface
- WIDTH, 32: operand width; must be even; product width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, all state holds.
- A  input  WIDTH  signed multiplicand (two's complement).
- B  input  WIDTH  signed multiplier (two's complement), Booth-recoded.
- OUT  output  2*WIDTH  signed product A*B, registered.

## Operation
- States: LOAD, BUSY, DONE.
- Reset (rst=0, asynchronous): state=LOAD, OUT=0, accumulator=0, digit counter=0.
- LOAD: on the first rising edge with en=1:
  - capture A into the multiplicand register, sign-extended to WIDTH+2 bits;
  - capture B into the multiplier register with an appended B[-1]=0;
  - clear the accumulator; go to BUSY.
- BUSY: on each enabled edge, process one radix-4 digit i (i = 0 … WIDTH/2-1), using triplet {B[2i+1], B[2i], B[2i-1]}:
  - 000 or 111 → 0
  - 001 or 010 → +M
  - 011 → +2M
  - 100 → -2M
  - 101 or 110 → -M
  - The partial product is weighted by 4^i and added to a 2*WIDTH-bit (or wider) signed accumulator. A shift-right accumulator formulation is permitted if the result is bit-exact.
  - After digit WIDTH/2-1, load OUT with the low 2*WIDTH bits of the final sum; go to DONE.
- DONE: OUT holds the product. A, B and en are ignored until the next reset; a new multiplication requires a reset pulse.
- The product is exact for all operand pairs, including A=B=-2^(WIDTH-1), whose product is 2^(2*WIDTH-2).
- A and B changes after the LOAD capture edge do not affect the result.
- OUT stays at its previous value (0 after reset) during BUSY. There are no intermediate values on OUT.

## Timing
- Latency: the capture edge, plus WIDTH/2 enabled edges (16 for WIDTH=32). OUT is valid after the 16th BUSY edge, i.e. 17 enabled edges after reset release.
- en=0 freezes the state, counter and accumulator. Latency counts enabled edges only.
- Reset asserted mid-BUSY aborts the operation immediately: OUT=0, state=LOAD.
- Reset deassertion is synchronized by the integrator. The block assumes rst is released away from a clk edge.
- Throughput: one product per reset cycle.

## Configuration
- RADIX_BOOTH_DONE_EN defined: adds an output port done (1 bit).
  - done is 0 on reset, in LOAD and in BUSY.
  - done is 1 in DONE; it asserts in the same cycle OUT becomes valid.
- RADIX_BOOTH_DONE_EN undefined: no done port; the integrator waits a fixed WIDTH/2+1 enabled cycles. The datapath and latency are identical in both builds.

## Test plan
- Basic signs:
  - rst pulse, en=1, A=12, B=-32; after ≥17 edges → OUT=-384.
  - Repeat with reset between cases: 5×15 → 75; -51×-4 → 204; -25×-60 → 1500.
- Zero/identity: 0×1234 → 0; 1×12 → 12; -12×72 → -864; 13×20 → 260.
- Booth extremes:
  - A=B=-2^31 → OUT=2^62 (0x4000000000000000).
  - A=-2^31, B=2^31-1 → -2^62+2^31.
  - B=0x55555555 and B=0xAAAAAAAA with A=-1 → exact products.
- en stall: toggle en low for random cycles during BUSY → OUT unchanged until 17 enabled edges have occurred, then correct. With RADIX_BOOTH_DONE_EN, done asserts on exactly the 17th enabled edge.
- Reset mid-op: assert rst after 8 BUSY edges → OUT=0 immediately. After release, a new A=7, B=-3 → OUT=-21.
- Operand change after capture: alter A and B during BUSY → OUT equals the product of the captured values.
